// File: rtl/mem_wb_stage.sv
// Memory + write-back stage: EX/MEM register, word-addressed synchronous data
// memory (LW/SW), MEM/WB register driving the register file write port.
// Loads may take MEM_WAIT extra cycles; during that time EX is back-pressured.
module mem_wb_stage #(
    parameter int          ADDR_W   = 8,
    parameter int          MEM_WAIT = 0,
    parameter logic [5:0]  OP_LW    = 6'h23,
    parameter logic [5:0]  OP_SW    = 6'h2B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [5:0]  ex_opcode,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_dest,
    input  logic        ex_reg_write,
    output logic        wb_write,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        err_misaligned
);

    typedef enum logic { S_RUN, S_WAIT } state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;

    // EX/MEM register
    logic        m_valid;
    logic        m_is_lw;
    logic        m_is_sw;
    logic        m_mis;
    logic        m_wr;
    logic [4:0]  m_dest;
    logic [31:0] m_result;
    logic [31:0] m_sdata;

    logic [31:0] mem [1 << ADDR_W];

    logic              accept;
    logic              ex_is_lw;
    logic              ex_is_sw;
    logic              ex_mis;
    logic              retire;
    logic [ADDR_W-1:0] m_idx;

    assign ex_is_lw = (ex_opcode == OP_LW);
    assign ex_is_sw = (ex_opcode == OP_SW);
    assign ex_mis   = (ex_is_lw | ex_is_sw) & (ex_alu_result[1:0] != 2'b00);
    assign accept   = ex_valid & ex_ready;
    // The instruction in M completes only once any load wait has elapsed;
    // leaving WAIT puts the FSM back in RUN for the read edge itself.
    assign retire   = m_valid & (state == S_RUN);
    // Upper address bits are dropped so addresses wrap around the memory.
    assign m_idx    = m_result[ADDR_W+1:2];

    // Next-state: an aligned LW accepted with MEM_WAIT>0 stalls EX for MEM_WAIT
    // cycles; cnt holds the remaining stall cycles and returns to RUN as it
    // runs out, so the read and the next accept share the same edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ex_ready  = (state == S_RUN);
        case (state)
            S_RUN: begin
                if (accept && ex_is_lw && !ex_mis && MEM_WAIT != 0) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = 3'(MEM_WAIT);
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1) state_nxt = S_RUN;
            end
            default: state_nxt = S_RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // EX/MEM register: loads a new instruction whenever the stage is ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_is_lw  <= 1'b0;
            m_is_sw  <= 1'b0;
            m_mis    <= 1'b0;
            m_wr     <= 1'b0;
            m_dest   <= 5'd0;
            m_result <= 32'd0;
            m_sdata  <= 32'd0;
        end else if (ex_ready) begin
            m_valid <= ex_valid;
            if (ex_valid) begin
                m_is_lw  <= ex_is_lw;
                m_is_sw  <= ex_is_sw;
                m_mis    <= ex_mis;
                m_wr     <= ex_reg_write & (ex_dest != 5'd0);
                m_dest   <= ex_dest;
                m_result <= ex_alu_result;
                m_sdata  <= ex_store_data;
            end
        end
    end

    // Data memory write port: aligned stores commit on their retire edge
    always_ff @(posedge clk) begin
        if (rst_n && retire && m_is_sw && !m_mis)
            mem[m_idx] <= m_sdata;
    end

    // MEM/WB register: one-cycle write pulse, address/data held otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_write       <= 1'b0;
            wb_addr        <= 5'd0;
            wb_data        <= 32'd0;
            err_misaligned <= 1'b0;
        end else begin
            wb_write <= 1'b0;
            if (retire) begin
                if (m_mis) begin
                    err_misaligned <= 1'b1;
                end else if (m_wr && !m_is_sw) begin
                    wb_write <= 1'b1;
                    wb_addr  <= m_dest;
                    wb_data  <= m_is_lw ? mem[m_idx] : m_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: three instances with MEM_WAIT = 0, 2, 3 share the
// data fields of the EX interface, each with its own ex_valid. An event-list
// model (retire edge per instruction, flat memory array) predicts every output
// each cycle; directed scenarios add explicit constant checks.
module tb_mem_wb_stage;

    localparam int NI = 3;
    localparam logic [5:0] LW = 6'h23;
    localparam logic [5:0] SW = 6'h2B;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid [NI];
    logic        ex_ready [NI];
    logic [5:0]  ex_opcode;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        wb_write [NI];
    logic [4:0]  wb_addr [NI];
    logic [31:0] wb_data [NI];
    logic        err [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_wb_stage #(.ADDR_W(8), .MEM_WAIT(g == 0 ? 0 : g + 1)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .ex_valid(ex_valid[g]), .ex_ready(ex_ready[g]),
            .ex_opcode(ex_opcode), .ex_alu_result(ex_alu_result),
            .ex_store_data(ex_store_data), .ex_dest(ex_dest),
            .ex_reg_write(ex_reg_write),
            .wb_write(wb_write[g]), .wb_addr(wb_addr[g]), .wb_data(wb_data[g]),
            .err_misaligned(err[g])
        );
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        int          due;
        bit          ld, st, mis, wr;
        logic [4:0]  dest;
        logic [31:0] data;
        int          idx;
    } ev_t;

    ev_t         pend [NI][4];
    int          stall [NI];
    logic [31:0] mm [NI][256];
    logic        e_wr [NI];
    logic [4:0]  e_addr [NI];
    logic [31:0] e_data [NI];
    logic        e_err [NI];
    int          ecnt;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int wait_of(input int i);
        return (i == 0) ? 0 : i + 1;
    endfunction

    // What happens to instance i at the rising edge numbered ecnt
    function automatic void model_edge(input int i);
        bit acc, ld, st, mis;
        int w;
        w = wait_of(i);
        if (!rst_n) begin
            for (int p = 0; p < 4; p++) pend[i][p].v = 0;
            stall[i] = 0;
            e_wr[i] = 0; e_addr[i] = '0; e_data[i] = '0; e_err[i] = 0;
            return;
        end
        acc = ex_valid[i] && (stall[i] == 0);
        e_wr[i] = 0;
        for (int p = 0; p < 4; p++) begin
            if (pend[i][p].v && pend[i][p].due == ecnt) begin
                pend[i][p].v = 0;
                if (pend[i][p].mis) e_err[i] = 1;
                else if (pend[i][p].st) mm[i][pend[i][p].idx] = pend[i][p].data;
                else if (pend[i][p].wr) begin
                    e_wr[i]   = 1;
                    e_addr[i] = pend[i][p].dest;
                    e_data[i] = pend[i][p].ld ? mm[i][pend[i][p].idx] : pend[i][p].data;
                end
            end
        end
        if (stall[i] > 0) stall[i]--;
        if (acc) begin
            ld  = (ex_opcode == LW);
            st  = (ex_opcode == SW);
            mis = (ld || st) && (ex_alu_result[1:0] != 2'b00);
            for (int p = 0; p < 4; p++) begin
                if (!pend[i][p].v) begin
                    pend[i][p].v    = 1;
                    pend[i][p].due  = ecnt + 1 + ((ld && !mis) ? w : 0);
                    pend[i][p].ld   = ld;
                    pend[i][p].st   = st;
                    pend[i][p].mis  = mis;
                    pend[i][p].wr   = ex_reg_write && (ex_dest != 5'd0);
                    pend[i][p].dest = ex_dest;
                    pend[i][p].data = st ? ex_store_data : ex_alu_result;
                    pend[i][p].idx  = int'(ex_alu_result[9:2]);
                    break;
                end
            end
            if (ld && !mis && w > 0) stall[i] = w;
        end
    endfunction

    // One clock: drive at negedge, model the edge, compare at next negedge
    task automatic cyc(input bit rst, input logic [2:0] vm, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] d, input bit rw);
        rst_n = !rst;
        for (int i = 0; i < NI; i++) ex_valid[i] = vm[i];
        ex_opcode = op; ex_alu_result = a; ex_store_data = sd;
        ex_dest = d; ex_reg_write = rw;
        @(posedge clk);
        ecnt++;
        for (int i = 0; i < NI; i++) model_edge(i);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("ready%0d", i), 32'(ex_ready[i]), 32'(stall[i] == 0));
            chk($sformatf("wb_write%0d", i), 32'(wb_write[i]), 32'(e_wr[i]));
            chk($sformatf("wb_addr%0d", i), 32'(wb_addr[i]), 32'(e_addr[i]));
            chk($sformatf("wb_data%0d", i), wb_data[i], e_data[i]);
            chk($sformatf("err%0d", i), 32'(err[i]), 32'(e_err[i]));
        end
    endtask

    task automatic idle();
        cyc(0, 3'b000, 6'd0, 32'd0, 32'd0, 5'd0, 0);
    endtask

    initial begin
        ecnt = 0;
        for (int i = 0; i < NI; i++) begin
            stall[i] = 0; e_wr[i] = 0; e_addr[i] = '0; e_data[i] = '0; e_err[i] = 0;
            for (int p = 0; p < 4; p++) pend[i][p].v = 0;
            for (int m = 0; m < 256; m++) mm[i][m] = '0;
        end
        rst_n = 0;
        for (int i = 0; i < NI; i++) ex_valid[i] = 0;
        ex_opcode = 0; ex_alu_result = 0; ex_store_data = 0; ex_dest = 0; ex_reg_write = 0;
        @(negedge clk);

        // Reset state
        cyc(1, 3'b111, 6'd0, 32'h1, 32'h0, 5'd1, 1);
        cyc(1, 3'b000, 6'd0, 32'h0, 32'h0, 5'd0, 0);
        for (int i = 0; i < NI; i++) begin
            chk("rst_ready", 32'(ex_ready[i]), 32'd1);
            chk("rst_wb_write", 32'(wb_write[i]), 32'd0);
            chk("rst_wb_data", wb_data[i], 32'd0);
            chk("rst_err", 32'(err[i]), 32'd0);
        end

        // Initialise words 0..7 in every instance
        for (int m = 0; m < 8; m++)
            cyc(0, 3'b111, SW, 32'(m * 4), $urandom, 5'd0, 0);

        // 1: SW then LW same address, back-to-back, MEM_WAIT=0
        cyc(0, 3'b001, SW, 32'h10, 32'hDEADBEEF, 5'd0, 0);
        cyc(0, 3'b001, LW, 32'h10, 32'h0, 5'd5, 1);
        idle();
        chk("t1_write", 32'(wb_write[0]), 32'd1);
        chk("t1_addr", 32'(wb_addr[0]), 32'd5);
        chk("t1_data", wb_data[0], 32'hDEADBEEF);

        // 2: four back-to-back ALU ops
        for (int j = 0; j <= 4; j++) begin
            if (j < 4) cyc(0, 3'b001, 6'd0, 32'h11 * (j + 1), 32'h0, 5'(j + 1), 1);
            else       idle();
            chk("t2_ready", 32'(ex_ready[0]), 32'd1);
            if (j > 0) begin
                chk("t2_write", 32'(wb_write[0]), 32'd1);
                chk("t2_addr", 32'(wb_addr[0]), 32'(j));
                chk("t2_data", wb_data[0], 32'h11 * j);
            end
        end

        // 3: MEM_WAIT=2, LW followed by held ALU op
        cyc(0, 3'b010, SW, 32'h10, 32'h12345678, 5'd0, 0);
        cyc(0, 3'b010, LW, 32'h10, 32'h0, 5'd6, 1);
        chk("t3_stall1", 32'(ex_ready[1]), 32'd0);
        cyc(0, 3'b010, 6'd0, 32'h77, 32'h0, 5'd7, 1);
        chk("t3_stall2", 32'(ex_ready[1]), 32'd0);
        chk("t3_nowb", 32'(wb_write[1]), 32'd0);
        cyc(0, 3'b010, 6'd0, 32'h77, 32'h0, 5'd7, 1);
        chk("t3_ready", 32'(ex_ready[1]), 32'd1);
        cyc(0, 3'b010, 6'd0, 32'h77, 32'h0, 5'd7, 1);
        chk("t3_lw_write", 32'(wb_write[1]), 32'd1);
        chk("t3_lw_addr", 32'(wb_addr[1]), 32'd6);
        chk("t3_lw_data", wb_data[1], 32'h12345678);
        idle();
        chk("t3_alu_addr", 32'(wb_addr[1]), 32'd7);
        chk("t3_alu_data", wb_data[1], 32'h77);

        // 4: misaligned SW leaves memory alone, flags error
        cyc(0, 3'b001, SW, 32'h10, 32'hCAFEF00D, 5'd0, 0);
        cyc(0, 3'b001, SW, 32'h13, 32'h0, 5'd0, 0);
        idle();
        chk("t4_err", 32'(err[0]), 32'd1);
        cyc(0, 3'b001, LW, 32'h10, 32'h0, 5'd8, 1);
        idle();
        chk("t4_data", wb_data[0], 32'hCAFEF00D);
        chk("t4_err_sticky", 32'(err[0]), 32'd1);

        // 5: dest 0 never writes
        cyc(0, 3'b001, 6'd0, 32'hFFFFFFFF, 32'h0, 5'd0, 1);
        idle();
        chk("t5_nowrite", 32'(wb_write[0]), 32'd0);

        // 6: MEM_WAIT=3, reset during WAIT aborts the load
        cyc(0, 3'b100, LW, 32'h10, 32'h0, 5'd9, 1);
        idle();
        chk("t6_waiting", 32'(ex_ready[2]), 32'd0);
        cyc(1, 3'b000, 6'd0, 32'h0, 32'h0, 5'd0, 0);
        chk("t6_ready", 32'(ex_ready[2]), 32'd1);
        chk("t6_addr", 32'(wb_addr[2]), 32'd0);
        chk("t6_data", wb_data[2], 32'd0);
        for (int j = 0; j < 5; j++) begin
            idle();
            chk("t6_nowb", 32'(wb_write[2]), 32'd0);
        end

        // Random traffic; addresses cover words 0..7 with wrapped upper bits
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a;
            logic [5:0]  op;
            logic [2:0]  vm;
            int          r;
            r = $urandom_range(0, 9);
            op = (r <= 2) ? LW : (r <= 4) ? SW : (r == 5) ? 6'($urandom) : 6'd0;
            a = $urandom;
            a[9:5] = 5'd0;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            for (int i = 0; i < NI; i++) vm[i] = ($urandom_range(0, 4) != 0);
            cyc($urandom_range(0, 199) == 0, vm, op, a, $urandom,
                5'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
